// File: rtl/preproc_norm_pipe.sv
// Pixel normaliser: out = sat(((in*scale + rnd) >> SHIFT) - offset), per-channel scale/offset.
// Two register stages (product, then shift/subtract/clamp) sharing one valid/ready stall.

module preproc_norm_cfg_lane #(
  parameter int SCALE_W    = 8,
  parameter int OFF_W      = 8,
  parameter int DEF_SCALE  = 147,
  parameter int DEF_OFFSET = 19
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [SCALE_W-1:0] scale_i,
  input  logic [OFF_W-1:0]   offset_i,
  output logic [SCALE_W-1:0] scale_o,
  output logic [OFF_W-1:0]   offset_o
);
  logic [SCALE_W-1:0] scale_q;
  logic [OFF_W-1:0]   offset_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scale_q  <= SCALE_W'(DEF_SCALE);
      offset_q <= OFF_W'(DEF_OFFSET);
    end else if (we_i) begin
      scale_q  <= scale_i;
      offset_q <= offset_i;
    end
  end

  assign scale_o  = scale_q;
  assign offset_o = offset_q;
endmodule

module preproc_norm_pipe #(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 8,
  parameter int SCALE_W    = 8,
  parameter int OFF_W      = 8,
  parameter int SHIFT      = 8,
  parameter int NUM_CH     = 1,
  parameter int ROUND      = 0,
  parameter int DEF_SCALE  = 147,
  parameter int DEF_OFFSET = 19,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [IN_W-1:0]    in_data_i,
  input  logic               in_sof_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [OUT_W-1:0]   out_data_o,
  output logic [CH_W-1:0]    out_ch_o,
  output logic               out_sof_o,
  input  logic               cfg_we_i,
  input  logic [CH_W-1:0]    cfg_ch_i,
  input  logic [SCALE_W-1:0] cfg_scale_i,
  input  logic [OFF_W-1:0]   cfg_offset_i,
  output logic [15:0]        sat_cnt_o
);
  localparam int STAGES = 2;
  localparam int PROD_W = IN_W + SCALE_W;
  localparam int SH_W   = PROD_W + 1;
  localparam int DIFF_W = ((SH_W > OFF_W) ? SH_W : OFF_W) + 2;
  localparam logic [SH_W-1:0] RND = (ROUND != 0) ? (SH_W'(1) << (SHIFT - 1)) : '0;
  localparam logic signed [DIFF_W-1:0] OMAX = DIFF_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [DIFF_W-1:0] OMIN = DIFF_W'(-(1 << (OUT_W - 1)));

  typedef struct packed {
    logic [PROD_W-1:0] prod;
    logic [CH_W-1:0]   ch;
    logic              sof;
    logic [OFF_W-1:0]  off;
  } s1_t;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [CH_W-1:0]  ch;
    logic             sof;
    logic             sat;
  } s2_t;

  logic [STAGES:1] vld_pipe_q;
  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;
  logic [CH_W-1:0] ch_cnt_q, ch_cur, ch_nxt;
  logic [15:0]     sat_cnt_q, sat_cnt_d;
  logic            stall, accept;

  logic [NUM_CH-1:0][SCALE_W-1:0] scale_all;
  logic [NUM_CH-1:0][OFF_W-1:0]   off_all;
  logic [SCALE_W-1:0]             scale_sel;
  logic [OFF_W-1:0]               off_sel;

  assign stall      = vld_pipe_q[STAGES] & ~out_ready_i;
  assign in_ready_o = ~stall;
  assign accept     = in_valid_i & ~stall;

  // Out-of-range cfg_ch matches no lane, so the write is dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    preproc_norm_cfg_lane #(
      .SCALE_W(SCALE_W), .OFF_W(OFF_W), .DEF_SCALE(DEF_SCALE), .DEF_OFFSET(DEF_OFFSET)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_i     (cfg_we_i && (cfg_ch_i == CH_W'(g))),
      .scale_i  (cfg_scale_i),
      .offset_i (cfg_offset_i),
      .scale_o  (scale_all[g]),
      .offset_o (off_all[g])
    );
  end

  assign ch_cur = in_sof_i ? '0 : ch_cnt_q;
  assign ch_nxt = (ch_cur == CH_W'(NUM_CH - 1)) ? '0 : ch_cur + CH_W'(1);

  always_comb begin
    scale_sel = '0;
    off_sel   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_cur == CH_W'(c)) begin
        scale_sel = scale_all[c];
        off_sel   = off_all[c];
      end
    end
  end

  always_comb begin
    s1_d      = '0;
    s1_d.prod = PROD_W'(in_data_i) * PROD_W'(scale_sel);
    s1_d.ch   = ch_cur;
    s1_d.sof  = in_sof_i;
    s1_d.off  = off_sel;
  end

  // One spare bit on the rounded product so the rounding add never loses its carry.
  logic [SH_W-1:0]          sh;
  logic signed [DIFF_W-1:0] diff;

  always_comb begin
    sh   = ({1'b0, s1_q.prod} + RND) >> SHIFT;
    diff = $signed({{(DIFF_W - SH_W){1'b0}}, sh})
         - $signed({{(DIFF_W - OFF_W){s1_q.off[OFF_W-1]}}, s1_q.off});
    s2_d      = '0;
    s2_d.ch   = s1_q.ch;
    s2_d.sof  = s1_q.sof;
    if (diff > OMAX) begin
      s2_d.data = OMAX[OUT_W-1:0];
      s2_d.sat  = 1'b1;
    end else if (diff < OMIN) begin
      s2_d.data = OMIN[OUT_W-1:0];
      s2_d.sat  = 1'b1;
    end else begin
      s2_d.data = diff[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      ch_cnt_q   <= '0;
    end else if (!stall) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], accept};
      if (accept) begin
        s1_q     <= s1_d;
        ch_cnt_q <= ch_nxt;
      end
      if (vld_pipe_q[1]) s2_q <= s2_d;
    end
  end

  // A new frame wins over a saturated beat leaving in the same cycle.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (accept && in_sof_i)
      sat_cnt_d = '0;
    else if (vld_pipe_q[STAGES] && out_ready_i && s2_q.sat && (sat_cnt_q != 16'hFFFF))
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign out_valid_o = vld_pipe_q[STAGES];
  assign out_data_o  = s2_q.data;
  assign out_ch_o    = s2_q.ch;
  assign out_sof_o   = s2_q.sof;
  assign sat_cnt_o   = sat_cnt_q;
endmodule
